// File: rtl/enc_fhs.sv
// FHS payload encoder: latches fields at start, serializes 144 payload bits LSB-first per field, then 16 CRC bits MSB-first.
// Latency: one bit per py_bitreq_p, registered, valid 1 cycle after request; start pulse aborts and restarts.
module enc_fhs (
    input  logic        clk_6M,
    input  logic        rstz,
    input  logic        enc_py_st_p,
    input  logic        py_bitreq_p,
    input  logic [33:0] Pbits,
    input  logic [23:0] LAP,
    input  logic        EIR,
    input  logic [1:0]  SR,
    input  logic [1:0]  SP,
    input  logic [7:0]  UAP,
    input  logic [15:0] NAP,
    input  logic [23:0] CoD,
    input  logic [2:0]  LT_ADDR,
    input  logic [25:0] CLK,
    input  logic [2:0]  PSM,
    input  logic [7:0]  crc_init,
    output logic        pyencdatout,
    output logic        py_datvalid_p,
    output logic        enc_busy,
    output logic        enc_done_p,
    output logic [7:0]  bitcount
);

    localparam int PY_BITS  = 144;
    localparam int CRC_BITS = 16;
    localparam logic [7:0] LAST_PY  = 8'(PY_BITS - 1);
    localparam logic [7:0] LAST_BIT = 8'(PY_BITS + CRC_BITS - 1);
    localparam logic [15:0] CRC_POLY = 16'h1021;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PAYLOAD = 2'd1,
        CRC     = 2'd2
    } state_t;

    state_t               state, state_nxt;
    logic [PY_BITS-1:0]   shreg;
    logic [15:0]          lfsr;
    logic                 py_step, crc_step, last_step;
    logic [PY_BITS-1:0]   py_load;

    // Bit 0 of the concatenation is the first bit on air; bit 59 is reserved.
    assign py_load = {PSM, CLK, LT_ADDR, CoD, NAP, UAP, SP, SR, 1'b0, EIR, LAP, Pbits};

    always_ff @(posedge clk_6M or negedge rstz) begin
        if (!rstz) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        py_step   = 1'b0;
        crc_step  = 1'b0;
        last_step = 1'b0;
        if (enc_py_st_p) begin
            state_nxt = PAYLOAD;
        end else if (py_bitreq_p) begin
            case (state)
                PAYLOAD: begin
                    py_step = 1'b1;
                    if (bitcount == LAST_PY) begin
                        state_nxt = CRC;
                    end
                end
                CRC: begin
                    crc_step = 1'b1;
                    if (bitcount == LAST_BIT) begin
                        last_step = 1'b1;
                        state_nxt = IDLE;
                    end
                end
                default: state_nxt = state;
            endcase
        end
    end

    assign enc_busy = (state != IDLE);

    always_ff @(posedge clk_6M or negedge rstz) begin
        if (!rstz) begin
            shreg         <= '0;
            lfsr          <= '0;
            bitcount      <= '0;
            pyencdatout   <= 1'b0;
            py_datvalid_p <= 1'b0;
            enc_done_p    <= 1'b0;
        end else begin
            py_datvalid_p <= py_step | crc_step;
            enc_done_p    <= last_step;
            if (enc_py_st_p) begin
                shreg    <= py_load;
                lfsr     <= {8'h00, crc_init};
                bitcount <= '0;
            end else if (py_step) begin
                pyencdatout <= shreg[0];
                shreg       <= {1'b0, shreg[PY_BITS-1:1]};
                lfsr        <= {lfsr[14:0], 1'b0} ^ ((lfsr[15] ^ shreg[0]) ? CRC_POLY : 16'h0000);
                bitcount    <= bitcount + 8'd1;
            end else if (crc_step) begin
                pyencdatout <= lfsr[15];
                lfsr        <= {lfsr[14:0], 1'b0};
                bitcount    <= bitcount + 8'd1;
            end
        end
    end

endmodule
